fft_bin_reorder: RTL and testbench
==================================

Name: fft_bin_reorder

Overview:
- Converts the FFT output stream from bit-reversed bin order to natural bin order (0..N-1).
- Sits directly upstream of the frequency-domain filter stage, which indexes bins by counting from the sync pulse and therefore needs natural order.
- Uses ping-pong frame buffering: one bank is written with the incoming frame while the other bank is read out in natural order.
- Stream is throttled purely by i_ce. There is no backpressure.

Parameters:
- WIDTH, 21, bits per real/imag component; a sample is {re, im} packed into 2*WIDTH bits.
- LGSIZE, 9, log2 of FFT size N; N = 1<<LGSIZE bins per frame.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_ce  in  1  input sample strobe; qualifies i_sample and i_sync.
- i_sample  in  2*WIDTH  bin in bit-reversed order; re in [2W-1:W], im in [W-1:0].
- i_sync  in  1  marks the first sample of a frame; valid only with i_ce.
- o_ce  out  1  output sample strobe.
- o_sample  out  2*WIDTH  bin in natural order.
- o_sync  out  1  high with o_ce on natural bin 0.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - o_ce=0, o_sample=0, o_sync=0.
  - state=WAIT_SYNC, wr_idx=0, bank=0.
  - RAM contents are don't-care.
- States:
  - WAIT_SYNC: samples are discarded. An i_ce&&i_sync cycle writes that sample to slot bitrev(0)=0 of bank, sets wr_idx=1 and moves to FILL.
  - FILL: each i_ce writes i_sample into bank at address bitrev(wr_idx), then wr_idx++. On the write with wr_idx==N-1: wr_idx wraps to 0, bank toggles, state moves to STREAM. o_ce stays 0 in FILL.
  - STREAM: each i_ce writes the incoming sample to bank at bitrev(wr_idx) and reads bank ^ 1 at address wr_idx (natural order). Frame end toggles bank exactly as in FILL.
- Output timing:
  - Read is synchronous; o_sample is registered from the RAM.
  - o_ce is registered: o_ce <= i_ce && (state==STREAM).
  - o_sync is registered: o_sync <= i_ce && (state==STREAM) && (wr_idx==0).
  - o_sample holds its value when o_ce=0.
- Latency: natural bin k of frame f is output one clock after the i_ce that carries position k of frame f+1. The first frame produces no output until the next frame is streaming in.
- Sync rules:
  - i_sync at wr_idx==0 in STREAM: normal, no effect.
  - Missing i_sync at the frame boundary: accepted; the block free-runs on its count.
  - Early i_sync (i_ce&&i_sync with wr_idx!=0, in FILL or STREAM):
    - The partial frame is abandoned and output is aborted.
    - Sample goes to slot 0, wr_idx=1, bank unchanged, state=FILL.
    - o_ce=0 from the next cycle until a full frame has been collected.
- i_sync without i_ce is ignored.
- bitrev(x) reverses the LGSIZE-bit index. Write and read addresses are {bank_select, index}.
- Reset mid-frame: everything returns immediately to reset values; all buffered data is lost.

Optional Feature:
- Macro: FFT_REORDER_SYNC_ERR_EN.
- Defined:
  - Adds output port o_sync_err (1 bit) and an internal 8-bit saturating counter, err_cnt.
  - o_sync_err pulses high for one clock, registered, on every early-sync event.
  - err_cnt increments on each early-sync event and saturates at 255. It is exposed as output o_sync_err_cnt (8 bits).
  - Both reset to 0.
- Undefined: neither port exists; early sync is handled silently as in Behaviour.

Decomposition:
- Package fft_pkg holds:
  - Default WIDTH and LGSIZE.
  - Typedef sample_t (logic [2*WIDTH-1:0]).
  - Function bitrev (parameterised by LGSIZE).
  - State enum {WAIT_SYNC, FILL, STREAM}.
- One sub-module, pingpong_ram: a simple dual-port RAM of 2N x 2*WIDTH with one write port and one registered read port, no reset on storage.
- Control FSM and counters live in fft_bin_reorder.

Test Plan:
- All tests use LGSIZE=3 (bitrev order 0,4,2,6,1,5,3,7).
- Basic reorder: feed 2 frames, i_ce constant 1, sample value = natural bin (0,4,2,6,1,5,3,7), i_sync on first -> during frame 2, o_sample = 0..7 in order, o_sync only with bin 0, first o_ce exactly 9 clocks after the first input.
- Throttled ce: same data with i_ce=1 every third clock -> identical output sequence; o_ce pulses only on the clock after each input i_ce; o_sample held between pulses.
- Pre-sync discard: 5 samples with no i_sync, then a frame with sync -> the 5 samples never appear; output begins with the following frame.
- Early sync: i_sync at wr_idx=3 in STREAM -> o_ce=0 from the next clock for 8 i_ce strobes, then a clean 0..7 sequence; with FFT_REORDER_SYNC_ERR_EN, o_sync_err pulses once and err_cnt=1.
- Async reset mid-frame: assert i_reset_n=0 between clock edges -> o_ce, o_sync, o_sample go to 0 immediately; after release, no output until a sync-started frame completes.
- Saturation (macro on): 300 early syncs -> o_sync_err_cnt=255.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, defaults and the index bit-reversal helper for the FFT bin reorder block.
package fft_pkg;

    localparam int DEF_WIDTH  = 21;
    localparam int DEF_LGSIZE = 9;

    typedef logic [2*DEF_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        FILL      = 2'd1,
        STREAM    = 2'd2
    } state_t;

    // Reverses the low lg bits of x; callers size-cast the result down to their index width.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int lg);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < lg) begin
                r[lg-1-i] = x[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bin_reorder_pingpong_ram.sv
// Two-bank frame store: one write port, one registered read port; the array itself is not reset.
module pingpong_ram #(
    parameter int AW = 10,
    parameter int DW = 42
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its last value when no read is issued
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_bin_reorder.sv
// Bit-reversed to natural-order FFT bin reorder using ping-pong frame banks.
// Optional sync-error reporting is enabled by defining FFT_REORDER_SYNC_ERR_EN.
module fft_bin_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LGSIZE = DEF_LGSIZE
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce,
    input  logic [2*WIDTH-1:0] i_sample,
    input  logic               i_sync,
    output logic               o_ce,
    output logic [2*WIDTH-1:0] o_sample,
    output logic               o_sync
`ifdef FFT_REORDER_SYNC_ERR_EN
    ,
    output logic               o_sync_err,
    output logic [7:0]         o_sync_err_cnt
`endif
);

    localparam logic [LGSIZE-1:0] LAST_IDX = LGSIZE'((1 << LGSIZE) - 1);

    state_t            state_q, state_d;
    logic [LGSIZE-1:0] wr_idx_q, wr_idx_d;
    logic              bank_q, bank_d;
    logic              o_ce_q, o_ce_d;
    logic              o_sync_q, o_sync_d;
    logic              early_s;
    logic              we_s;
    logic              re_s;
    logic [LGSIZE-1:0] widx_s;
`ifdef FFT_REORDER_SYNC_ERR_EN
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    // Next-state, RAM strobes and output strobes
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        bank_d   = bank_q;
        we_s     = 1'b0;
        re_s     = 1'b0;
        early_s  = i_ce && i_sync && (state_q != WAIT_SYNC) && (wr_idx_q != '0);
        widx_s   = LGSIZE'(bitrev(32'(wr_idx_q), LGSIZE));
        case (state_q)
            WAIT_SYNC: begin
                if (i_ce && i_sync) begin
                    we_s     = 1'b1;
                    widx_s   = '0;
                    wr_idx_d = LGSIZE'(1);
                    state_d  = FILL;
                end else begin
                    state_d  = WAIT_SYNC;
                end
            end
            FILL, STREAM: begin
                if (!i_ce) begin
                    state_d = state_q;
                end else if (early_s) begin
                    // Abandon the partial frame; the sync sample restarts it in the same bank
                    we_s     = 1'b1;
                    widx_s   = '0;
                    wr_idx_d = LGSIZE'(1);
                    state_d  = FILL;
                end else begin
                    we_s = 1'b1;
                    re_s = (state_q == STREAM);
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        bank_d   = ~bank_q;
                        state_d  = STREAM;
                    end else begin
                        wr_idx_d = wr_idx_q + LGSIZE'(1);
                    end
                end
            end
            default: begin
                state_d  = WAIT_SYNC;
                wr_idx_d = '0;
                bank_d   = 1'b0;
            end
        endcase
        o_ce_d   = re_s;
        o_sync_d = re_s && (wr_idx_q == '0);
`ifdef FFT_REORDER_SYNC_ERR_EN
        err_d     = early_s;
        err_cnt_d = (early_s && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
    end

    // Control FSM, counters and registered output strobes
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= WAIT_SYNC;
            wr_idx_q  <= '0;
            bank_q    <= 1'b0;
            o_ce_q    <= 1'b0;
            o_sync_q  <= 1'b0;
`ifdef FFT_REORDER_SYNC_ERR_EN
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            bank_q    <= bank_d;
            o_ce_q    <= o_ce_d;
            o_sync_q  <= o_sync_d;
`ifdef FFT_REORDER_SYNC_ERR_EN
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    pingpong_ram #(
        .AW (LGSIZE + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .we    (we_s),
        .waddr ({bank_q, widx_s}),
        .wdata (i_sample),
        .re    (re_s),
        .raddr ({~bank_q, wr_idx_q}),
        .rdata (o_sample)
    );

    assign o_ce   = o_ce_q;
    assign o_sync = o_sync_q;
`ifdef FFT_REORDER_SYNC_ERR_EN
    assign o_sync_err     = err_q;
    assign o_sync_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_fft_bin_reorder.sv
// Randomised scoreboard bench for fft_bin_reorder with a frame-level reference model (N=8).
module tb_fft_bin_reorder;

    localparam int WIDTH  = 8;
    localparam int LGSIZE = 3;
    localparam int N      = 1 << LGSIZE;
    localparam int SW     = 2 * WIDTH;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_ce = 1'b0;
    logic          i_sync = 1'b0;
    logic [SW-1:0] i_sample = '0;
    logic          o_ce;
    logic          o_sync;
    logic [SW-1:0] o_sample;
`ifdef FFT_REORDER_SYNC_ERR_EN
    logic          o_sync_err;
    logic [7:0]    o_sync_err_cnt;
`endif

    fft_bin_reorder #(.WIDTH(WIDTH), .LGSIZE(LGSIZE)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_sample  (i_sample),
        .i_sync    (i_sync),
        .o_ce      (o_ce),
        .o_sample  (o_sample),
        .o_sync    (o_sync)
`ifdef FFT_REORDER_SYNC_ERR_EN
        ,
        .o_sync_err     (o_sync_err),
        .o_sync_err_cnt (o_sync_err_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [SW-1:0] data;
        logic          sync;
        int            tag;
    } exp_t;

    exp_t          sb[$];
    bit            err_at[int];
    int            checks = 0;
    int            errors = 0;
    int            m_mode = 0;   // 0 waiting for sync, 1 collecting first frame, 2 streaming
    int            m_pos = 0;
    int            m_errcnt = 0;
    logic [SW-1:0] cur[N];
    logic [SW-1:0] prev[N];
    logic [SW-1:0] mon_last = '0;

    function automatic int rev(input int x);
        int r = 0;
        for (int i = 0; i < LGSIZE; i++) if (x[i]) r = r | (1 << (LGSIZE - 1 - i));
        return r;
    endfunction

    function automatic logic [SW-1:0] rnd();
        return SW'($urandom);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the reference model predicts the output it causes.
    task automatic drive(input bit ce, input bit sy, input logic [SW-1:0] s);
        bit   early;
        exp_t e;
        @(negedge i_clk);
        i_ce = ce; i_sync = sy; i_sample = s;
        if (ce) begin
            early = (m_mode != 0) && sy && (m_pos != 0);
            if (m_mode == 0) begin
                if (sy) begin cur[0] = s; m_pos = 1; m_mode = 1; end
            end else if (early) begin
                cur[0] = s; m_pos = 1; m_mode = 1;
                err_at[cyc + 1] = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end else begin
                if (m_mode == 2) begin
                    e.data = prev[m_pos]; e.sync = (m_pos == 0); e.tag = cyc + 1;
                    sb.push_back(e);
                end
                cur[rev(m_pos)] = s;
                if (m_pos == N - 1) begin prev = cur; m_pos = 0; m_mode = 2; end
                else m_pos++;
            end
        end
    endtask

    task automatic frame(input int gap, input bit with_sync);
        for (int p = 0; p < N; p++) begin
            repeat (gap) drive(1'b0, 1'($urandom_range(1)), rnd());
            drive(1'b1, with_sync && (p == 0), {8'($urandom_range(255)), 8'(rev(p))});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    task automatic check_cnt();
        drive(1'b0, 1'b0, '0);
`ifdef FFT_REORDER_SYNC_ERR_EN
        check("o_sync_err_cnt", 64'(o_sync_err_cnt), 64'(m_errcnt));
`endif
    endtask

    // Asserts reset between clock edges and checks outputs clear without waiting for a clock.
    task automatic do_reset();
        @(negedge i_clk);
        #1;
        i_reset_n = 1'b0;
        #1;
        check("reset_o_ce", 64'(o_ce), 64'd0);
        check("reset_o_sync", 64'(o_sync), 64'd0);
        check("reset_o_sample", 64'(o_sample), 64'd0);
        sb.delete(); err_at.delete();
        m_mode = 0; m_pos = 0; m_errcnt = 0;
        i_ce = 1'b0; i_sync = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each o_ce and checks idle-cycle behaviour.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (!i_reset_n) begin
                mon_last = '0;
            end else begin
`ifdef FFT_REORDER_SYNC_ERR_EN
                check("o_sync_err", 64'(o_sync_err), 64'(err_at.exists(cyc)));
`endif
                if (o_ce) begin
                    if (sb.size() == 0) begin
                        check("o_ce_unexpected", 64'(o_ce), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("o_ce_time", 64'(cyc), 64'(e.tag));
                        check("o_sample", 64'(o_sample), 64'(e.data));
                        check("o_sync", 64'(o_sync), 64'(e.sync));
                    end
                    mon_last = o_sample;
                end else begin
                    check("o_sync_idle", 64'(o_sync), 64'd0);
                    check("o_sample_hold", 64'(o_sample), 64'(mon_last));
                    if (sb.size() > 0 && sb[0].tag <= cyc) begin
                        check("o_ce_missing", 64'(o_ce), 64'd1);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge i_clk);
        check("init_o_ce", 64'(o_ce), 64'd0);
        check("init_o_sync", 64'(o_sync), 64'd0);
        check("init_o_sample", 64'(o_sample), 64'd0);
        i_reset_n = 1'b1;

        // Basic reorder, continuous strobe
        repeat (3) frame(0, 1'b1);
        idle(4);

        // Throttled strobe
        do_reset();
        repeat (3) frame(2, 1'b1);
        idle(4);

        // Pre-sync samples are discarded
        do_reset();
        repeat (5) drive(1'b1, 1'b0, rnd());
        repeat (3) frame(0, 1'b1);
        idle(4);

        // Early sync at position 3 while streaming
        do_reset();
        repeat (2) frame(0, 1'b1);
        for (int p = 0; p < 3; p++) drive(1'b1, p == 0, rnd());
        frame(0, 1'b1);
        repeat (2) frame(0, 1'b0);
        check_cnt();

        // Asynchronous reset mid-frame, then unsynced samples must stay silent
        repeat (2) frame(0, 1'b1);
        for (int p = 0; p < 4; p++) drive(1'b1, p == 0, rnd());
        do_reset();
        repeat (5) drive(1'b1, 1'b0, rnd());
        repeat (3) frame(1, 1'b1);
        idle(4);

        // Random strobe and sporadic sync
        do_reset();
        repeat (1500) drive($urandom_range(3) != 0, $urandom_range(40) == 0, rnd());
        check_cnt();

        // Repeated early syncs drive the error counter into saturation
        do_reset();
        drive(1'b1, 1'b1, rnd());
        repeat (300) begin
            drive(1'b1, 1'b0, rnd());
            drive(1'b1, 1'b1, rnd());
        end
        check_cnt();
        repeat (2) frame(0, 1'b1);
        idle(6);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
